// File: rtl/fir_ctrl_pkg.sv
// Shared FSM state type and default sizing for the FIR coefficient sequencer.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWrite,
        StFin
    } fir_state_e;

    localparam int unsigned DefNcoef = 129;
    localparam int unsigned DefC     = 16;
    localparam int unsigned DefAw    = 8;
    localparam int unsigned DefFsDiv = 104;

endpackage

// File: rtl/fir_fs_gen.sv
// Free-running sample-rate divider; the strobe is suppressed, never deferred, while en is low.
module fir_fs_gen #(
    parameter int unsigned FS_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic fs_stb
);

    localparam int unsigned   CW   = $clog2(FS_DIV);
    localparam logic [CW-1:0] Last = CW'(FS_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == Last) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign fs_stb = (cnt_q == Last) && en && !rst;

endmodule

// File: rtl/fir_coef_seq.sv
// Streams NCOEF coefficients from a synchronous ROM into the FIR and paces its input samples.
// Define FIR_COEF_SEQ_CSUM_EN to add a running checksum of the written coefficients on csum.
module fir_coef_seq
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned NCOEF  = DefNcoef,
    parameter int unsigned C      = DefC,
    parameter int unsigned AW     = DefAw,
    parameter int unsigned FS_DIV = DefFsDiv
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req,
    input  logic          load_bank,
    output logic [AW:0]   rom_addr,
    input  logic [C-1:0]  rom_data,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [C-1:0]  c_in,
    output logic          busy,
    output logic          done,
    output logic          fs_stb,
    output logic [C+7:0]  csum
);

    localparam logic [AW-1:0] LastIdx = AW'(NCOEF - 1);

    fir_state_e    state_q;
    logic          bank_q;
    logic          c_we_q;
    logic          busy_q;
    logic          done_q;
    logic [AW-1:0] c_addr_q;
    logic [C-1:0]  c_in_q;
    logic [AW:0]   rom_addr_q;

    // c_addr doubles as the write index; rom_addr runs one index ahead to cover ROM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bank_q     <= 1'b0;
            c_we_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            c_addr_q   <= '0;
            c_in_q     <= '0;
            rom_addr_q <= '0;
        end else begin
            c_we_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load_req) begin
                        state_q    <= StFetch;
                        bank_q     <= load_bank;
                        busy_q     <= 1'b1;
                        rom_addr_q <= {load_bank, {AW{1'b0}}};
                    end
                end
                StFetch: begin
                    state_q    <= StWrite;
                    c_we_q     <= 1'b1;
                    c_addr_q   <= '0;
                    rom_addr_q <= {bank_q, AW'(1)};
                end
                StWrite: begin
                    c_in_q <= rom_data;
                    if (c_addr_q == LastIdx) begin
                        state_q <= StFin;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        c_we_q     <= 1'b1;
                        c_addr_q   <= c_addr_q + AW'(1);
                        rom_addr_q <= {bank_q, c_addr_q + AW'(2)};
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ROM data arrives in the write cycle itself, so it is passed straight through while writing.
    assign c_in     = c_we_q ? rom_data : c_in_q;
    assign c_we     = c_we_q;
    assign c_addr   = c_addr_q;
    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

    fir_fs_gen #(
        .FS_DIV(FS_DIV)
    ) u_fs_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (!busy_q),
        .fs_stb(fs_stb)
    );

`ifdef FIR_COEF_SEQ_CSUM_EN
    logic [C+7:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (state_q == StIdle && load_req) begin
            csum_q <= '0;
        end else if (c_we_q) begin
            csum_q <= csum_q + {{8{rom_data[C-1]}}, rom_data};
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_fir_coef_seq.sv
// Bench for fir_coef_seq: synchronous ROM model, write/done scoreboard and sample-strobe model.
module tb_fir_coef_seq;
    import fir_ctrl_pkg::*;

    localparam int NCOEF  = 129;
    localparam int C      = 16;
    localparam int AW     = 8;
    localparam int FS_DIV = 104;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          load_req  = 1'b0;
    logic          load_bank = 1'b0;
    logic [AW:0]   rom_addr;
    logic [C-1:0]  rom_data;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [C-1:0]  c_in;
    logic          busy;
    logic          done;
    logic          fs_stb;
    logic [C+7:0]  csum;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [C-1:0]  data;
    } wr_t;

    wr_t          wr_q[$];
    int           done_q[$];
    int           cyc        = 0;
    int           ref_cnt    = 0;
    int           checks     = 0;
    int           errors     = 0;
    int           n_we       = 0;
    int           n_done     = 0;
    int           req_cyc    = 0;
    int           last_cyc   = 0;
    bit           active     = 1'b0;
    bit           mon_en     = 1'b0;
    logic         cur_bank   = 1'b0;
    logic         last_stb   = 1'b0;
    logic         stb_at_req = 1'b0;
    logic [C+7:0] exp_csum   = '0;

    always #5 clk = ~clk;

    fir_coef_seq #(
        .NCOEF (NCOEF),
        .C     (C),
        .AW    (AW),
        .FS_DIV(FS_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .load_bank(load_bank),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .fs_stb   (fs_stb),
        .csum     (csum)
    );

    // Bank 0 holds i+1; bank 1 holds a scrambled pattern with negative values.
    function automatic logic [C-1:0] rom_val(input logic [AW:0] a);
        logic [C-1:0] i;
        i = C'(a[AW-1:0]);
        if (!a[AW]) return i + C'(1);
        return (i * C'(517)) ^ C'(16'hC35A);
    endfunction

    always @(posedge clk) rom_data <= rom_val(rom_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || ref_cnt == FS_DIV - 1) ref_cnt <= 0;
        else ref_cnt <= ref_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        wr_t e;
        bit  exp_busy;
        last_stb = fs_stb;
        last_cyc = cyc;
        if (c_we === 1'b1) n_we++;
        if (done === 1'b1) n_done++;
        if (rst || !mon_en) return;
        exp_busy = active && (cyc > req_cyc) && (cyc <= req_cyc + NCOEF + 1);
        if (active && cyc == req_cyc) stb_at_req = fs_stb;
        check_eq("busy", 64'(busy), 64'(exp_busy));
        check_eq("fs_stb", 64'(fs_stb), 64'((ref_cnt == FS_DIV - 1) && !exp_busy));
        if (exp_busy) check_eq("rom_bank", 64'(rom_addr[AW]), 64'(cur_bank));
        if (active && cyc == req_cyc + 1)
            check_eq("rom_addr_fetch", 64'(rom_addr), 64'({cur_bank, AW'(0)}));
        if (c_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                check_eq("c_we_extra", 64'(c_we), 64'(0));
            end else begin
                e = wr_q.pop_front();
                check_eq("c_we_cycle", 64'(cyc), 64'(e.cyc));
                check_eq("c_addr", 64'(c_addr), 64'(e.addr));
                check_eq("c_in", 64'(c_in), 64'(e.data));
                if (int'(e.addr) < NCOEF - 1)
                    check_eq("rom_addr_next", 64'(rom_addr), 64'({cur_bank, e.addr + AW'(1)}));
            end
        end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
            check_eq("c_we_missing", 64'(c_we), 64'(1));
            e = wr_q.pop_front();
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) check_eq("done_extra", 64'(done), 64'(0));
            else check_eq("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
            check_eq("done_missing", 64'(done), 64'(1));
            void'(done_q.pop_front());
        end
    endtask

    // One clock: sample at the falling edge, return just after the next rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic pulse_load(input int t, input logic bank, input bit accept, output int req);
        wr_t e;
        wait_cyc(t);
        load_req  = 1'b1;
        load_bank = bank;
        req       = cyc;
        if (accept) begin
            active     = 1'b1;
            req_cyc    = cyc;
            cur_bank   = bank;
            exp_csum   = '0;
            n_we       = 0;
            n_done     = 0;
            stb_at_req = 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                e.cyc  = cyc + 2 + i;
                e.addr = AW'(i);
                e.data = rom_val({bank, AW'(i)});
                wr_q.push_back(e);
                exp_csum += {{8{e.data[C-1]}}, e.data};
            end
            done_q.push_back(cyc + NCOEF + 2);
        end
        step();
        load_req = 1'b0;
    endtask

    task automatic finish_load();
        for (int i = 0; i < 4 * NCOEF && (wr_q.size() != 0 || done_q.size() != 0); i++) step();
        check_eq("load_timeout", 64'(wr_q.size() + done_q.size()), 64'(0));
        repeat (3) step();
        check_eq("we_count", 64'(n_we), 64'(NCOEF));
        check_eq("done_count", 64'(n_done), 64'(1));
`ifdef FIR_COEF_SEQ_CSUM_EN
        check_eq("csum", 64'(csum), 64'(exp_csum));
`else
        check_eq("csum", 64'(csum), 64'(0));
`endif
        check_eq("c_addr_hold", 64'(c_addr), 64'(NCOEF - 1));
        check_eq("c_in_hold", 64'(c_in), 64'(rom_val({cur_bank, AW'(NCOEF - 1)})));
    endtask

    task automatic wait_strobe(output int s);
        s = -1;
        for (int i = 0; i < 3 * FS_DIV; i++) begin
            step();
            if (last_stb === 1'b1) begin
                s = last_cyc;
                break;
            end
        end
        if (s < 0) check_eq("stb_timeout", 64'(fs_stb), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_c_we"}, 64'(c_we), 64'(0));
        check_eq({tag, "_c_addr"}, 64'(c_addr), 64'(0));
        check_eq({tag, "_c_in"}, 64'(c_in), 64'(0));
        check_eq({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_done"}, 64'(done), 64'(0));
        check_eq({tag, "_csum"}, 64'(csum), 64'(0));
        check_eq({tag, "_idle"}, 64'(dut.state_q == StIdle), 64'(1));
    endtask

    initial begin
        int r, d, s1, s2, s3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check_eq("reset_fs_stb", 64'(fs_stb), 64'(0));
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // No load happens without a request.
        repeat (20) step();
        check_eq("no_autoload", 64'(n_we), 64'(0));

        // Bank 0 reference load.
        pulse_load(cyc + 2, 1'b0, 1'b1, r);
        finish_load();

        // Idle strobe period, then a load covering one wrap drops that strobe.
        wait_strobe(s1);
        wait_strobe(s2);
        check_eq("stb_period", 64'(s2 - s1), 64'(FS_DIV));
        pulse_load(s2 + 50, 1'b0, 1'b1, r);
        wait_strobe(s3);
        check_eq("stb_after_drop", 64'(s3), 64'(s2 + 2 * FS_DIV));
        finish_load();

        // Requests during the load and in the done cycle are ignored.
        pulse_load(cyc + 3, 1'b0, 1'b1, r);
        pulse_load(r + 5, 1'b1, 1'b0, d);
        pulse_load(r + 60, 1'b1, 1'b0, d);
        pulse_load(r + NCOEF + 2, 1'b1, 1'b0, d);
        finish_load();
        check_eq("fin_req_ignored", 64'(busy), 64'(0));

        // Reset on the 50th write aborts the load.
        pulse_load(cyc + 3, 1'b0, 1'b1, r);
        wait_cyc(r + 51);
        rst    = 1'b1;
        active = 1'b0;
        wr_q.delete();
        done_q.delete();
        step();
        rst = 1'b0;
        check_eq("abort_we_count", 64'(n_we), 64'(50));
        check_reset_outputs("abort");
        pulse_load(cyc + 2, 1'b0, 1'b1, r);
        finish_load();

        // Bank 1 load requested exactly on a counter wrap.
        wait_strobe(s1);
        pulse_load(s1 + FS_DIV, 1'b1, 1'b1, r);
        check_eq("stb_on_req", 64'(stb_at_req), 64'(1));
        finish_load();

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_coef_seq.md
FIR_COEF_SEQ -- requirements
Module: fir_coef_seq

Interface
REQ-001 Parameter NCOEF, default 129, number of unique coefficients written per load (addresses 0..NCOEF-1).
REQ-002 Parameter C, default 16, coefficient width in bits.
REQ-003 Parameter AW, default 8, coefficient address width; NCOEF SHALL be at most 2**AW.
REQ-004 Parameter FS_DIV, default 104, clk cycles per sample period; FS_DIV SHALL be at least 2.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 load_req  in  1  single-cycle request to reload coefficients.
REQ-008 load_bank  in  1  coefficient bank select, sampled with load_req.
REQ-009 rom_addr  out  AW+1  coefficient ROM address {bank, index}.
REQ-010 rom_data  in  C  ROM read data, valid exactly 1 cycle after rom_addr.
REQ-011 c_we  out  1  FIR coefficient write enable.
REQ-012 c_addr  out  AW  FIR coefficient write address.
REQ-013 c_in  out  C  FIR coefficient write data.
REQ-014 busy  out  1  high while a load is in progress.
REQ-015 done  out  1  1-cycle pulse when a load completes.
REQ-016 fs_stb  out  1  1-cycle sample strobe that advances the FIR input sample.
REQ-017 csum  out  C+8  checksum of the last load (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, FETCH, WRITE and FIN.
REQ-019 IDLE + load_req -> FETCH; latch load_bank; clear the index to 0; busy=1 from the next cycle.
REQ-020 FETCH SHALL drive rom_addr={bank,0} for one cycle, then go to WRITE (ROM priming cycle).
REQ-021 In WRITE, each cycle SHALL drive c_we=1, c_addr=k, c_in=rom_data for index k, while rom_addr presents index k+1.
REQ-022 After the write of k=NCOEF-1 -> FIN; rom_addr value after the last write is don't-care.
REQ-023 FIN SHALL pulse done=1 for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-024 Load latency: the first c_we is 2 cycles after load_req; done is NCOEF+2 cycles after load_req; exactly NCOEF c_we pulses occur per load.
REQ-025 load_req while busy=1 SHALL be ignored and not queued.
REQ-026 load_req in the FIN cycle SHALL be ignored.
REQ-027 c_we SHALL be 0 in IDLE, FETCH and FIN; c_addr and c_in hold their last value when c_we=0.
REQ-028 Sample counter SHALL count 0..FS_DIV-1 continuously and wrap to 0.
REQ-029 fs_stb SHALL be 1 only in a cycle where the counter equals FS_DIV-1 and busy=0.
REQ-030 A strobe that falls while busy=1 SHALL be dropped, not deferred.
REQ-031 load_req coinciding with a counter wrap: fs_stb SHALL still fire that cycle (busy is still 0).
REQ-032 After power-up reset, IDLE SHALL perform no automatic load; the system issues load_req.

Reset
REQ-033 rst=1 SHALL force IDLE, sample counter=0, c_we=0, c_addr=0, c_in=0, rom_addr=0, busy=0, done=0, fs_stb=0, csum=0.
REQ-034 rst asserted mid-load SHALL abort the load with no further c_we; the FIR contents are then partial and the system reloads.

Configuration
REQ-035 With FIR_COEF_SEQ_CSUM_EN defined, csum SHALL clear at load start, add the sign-extended c_in on every c_we (modulo 2**(C+8)), and hold after done.
REQ-036 With FIR_COEF_SEQ_CSUM_EN undefined, csum SHALL be constant 0 and no accumulator logic SHALL exist.

Structure
REQ-037 Package fir_ctrl_pkg SHALL hold the FSM state enum and the default constants NCOEF=129, C=16, FS_DIV=104.
REQ-038 The sample-rate divider SHALL be a sub-module fir_fs_gen (counter plus enable-gated strobe).

Verification
REQ-039 Reset, then load_req with bank 0 and ROM[i]=i+1: c_we at cycles 2..130, c_addr 0..128, c_in 1..129, done at cycle 131, csum=8385 (CSUM_EN).
REQ-040 load_req pulses at cycles 5 and 60 of a load: exactly 129 writes and one done.
REQ-041 Idle with FS_DIV=104: fs_stb every 104 cycles; a load spanning a wrap drops that strobe, and the next strobe arrives 104 cycles later.
REQ-042 rst at the 50th write: c_we=0 the next cycle, busy=0, state IDLE; a new load_req completes normally.
REQ-043 Bank 1 load: rom_addr MSB=1 throughout; data matches ROM[256+i]; csum=0 when CSUM_EN is undefined.
